// File: rtl/axi_wr_sched_pkg.sv
// rtl/axi_wr_sched_pkg.sv - shared state type and geometry constants for the write-burst scheduler
package axi_wr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DATA,
    DONE
  } state_e;

  localparam int BEAT_BYTES = 64;
  localparam int PAGE_BYTES = 4096;
  localparam int PAGE_BEATS = PAGE_BYTES / BEAT_BYTES;

endpackage

// File: rtl/wr_burst_calc.sv
// rtl/wr_burst_calc.sv - burst length = min(remaining, MAX_BURST, beats left in the 4 KB page)
module wr_burst_calc
  import axi_wr_sched_pkg::*;
#(
  parameter int LEN_WIDTH = 16,
  parameter int MAX_BURST = 64
) (
  input  logic [LEN_WIDTH-1:0] remaining,
  input  logic [5:0]           page_off,
  output logic [6:0]           burst
);

  logic [6:0] room;
  logic [6:0] cap;

  always_comb begin
    room  = 7'(PAGE_BEATS) - {1'b0, page_off};
    cap   = (7'(MAX_BURST) < room) ? 7'(MAX_BURST) : room;
    burst = (remaining < LEN_WIDTH'(cap)) ? remaining[6:0] : cap;
  end

endmodule

// File: rtl/axi_wr_burst_sched.sv
// rtl/axi_wr_burst_sched.sv - two-requester round-robin job scheduler that splits jobs into engine bursts
module axi_wr_burst_sched
  import axi_wr_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [LEN_WIDTH-1:0]  r0_beats,
  input  logic                  r0_den,
  input  logic [DATA_WIDTH-1:0] r0_din,
  output logic                  r0_drdy,
  output logic                  r0_done,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [LEN_WIDTH-1:0]  r1_beats,
  input  logic                  r1_den,
  input  logic [DATA_WIDTH-1:0] r1_din,
  output logic                  r1_drdy,
  output logic                  r1_done,
  input  logic                  lcl_ibusy,
  output logic                  lcl_istart,
  output logic [ADDR_WIDTH-1:0] lcl_iaddr,
  output logic [7:0]            lcl_inum,
  input  logic                  lcl_irdy,
  output logic                  lcl_den,
  output logic [DATA_WIDTH-1:0] lcl_din,
  output logic                  lcl_idone,
  output logic                  grant,
  output logic                  sched_busy
);

  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int PAGE_SHIFT = $clog2(PAGE_BYTES);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [6:0]            burst_q, burst_d;
  logic [6:0]            beat_cnt_q, beat_cnt_d;
  logic                  grant_q, grant_d;
  logic                  pref_q, pref_d;
  logic                  istart_q, istart_d;
  logic [ADDR_WIDTH-1:0] iaddr_q, iaddr_d;
  logic [7:0]            inum_q, inum_d;

  logic [6:0]            next_burst;
  logic                  win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [LEN_WIDTH-1:0]  win_beats;
  logic                  sel_den;

  wr_burst_calc #(
    .LEN_WIDTH(LEN_WIDTH),
    .MAX_BURST(MAX_BURST)
  ) u_calc (
    .remaining(rem_q),
    .page_off (addr_q[PAGE_SHIFT-1:BEAT_SHIFT]),
    .burst    (next_burst)
  );

  // pref_q names the requester that wins a tie; it flips away from whoever was just served
  assign win_idx   = (r0_valid & r1_valid) ? pref_q : r1_valid;
  assign win_addr  = win_idx ? r1_addr : r0_addr;
  assign win_beats = win_idx ? r1_beats : r0_beats;
  assign sel_den   = grant_q ? r1_den : r0_den;

  assign lcl_din    = grant_q ? r1_din : r0_din;
  assign lcl_istart = istart_q;
  assign lcl_iaddr  = iaddr_q;
  assign lcl_inum   = inum_q;
  assign grant      = grant_q;
  assign sched_busy = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    burst_d    = burst_q;
    beat_cnt_d = beat_cnt_q;
    grant_d    = grant_q;
    pref_d     = pref_q;
    istart_d   = 1'b0;
    iaddr_d    = iaddr_q;
    inum_d     = inum_q;
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    r0_drdy    = 1'b0;
    r1_drdy    = 1'b0;
    r0_done    = 1'b0;
    r1_done    = 1'b0;
    lcl_den    = 1'b0;
    lcl_idone  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (r0_valid | r1_valid) begin
          r0_ready = ~win_idx;
          r1_ready = win_idx;
          grant_d  = win_idx;
          addr_d   = win_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
          rem_d    = win_beats;
          state_d  = (win_beats == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (!lcl_ibusy) begin
          istart_d   = 1'b1;
          iaddr_d    = addr_q;
          inum_d     = {1'b0, next_burst};
          burst_d    = next_burst;
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        r0_drdy = ~grant_q & lcl_irdy;
        r1_drdy = grant_q & lcl_irdy;
        lcl_den = lcl_irdy & sel_den;
        if (lcl_den) begin
          if (beat_cnt_q == burst_q - 7'd1) begin
            lcl_idone  = 1'b1;
            beat_cnt_d = '0;
            rem_d      = rem_q - LEN_WIDTH'(burst_q);
            addr_d     = addr_q + (ADDR_WIDTH'(burst_q) << BEAT_SHIFT);
            state_d    = (rem_q == LEN_WIDTH'(burst_q)) ? DONE : ISSUE;
          end else begin
            beat_cnt_d = beat_cnt_q + 7'd1;
          end
        end
      end
      DONE: begin
        r0_done = ~grant_q;
        r1_done = grant_q;
        pref_d  = ~grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // abort wins over everything: no handshake or pulse leaks out in the abort cycle
    if (clear || !rst_n) begin
      state_d    = IDLE;
      pref_d     = 1'b0;
      grant_d    = 1'b0;
      beat_cnt_d = '0;
      istart_d   = 1'b0;
      r0_ready   = 1'b0;
      r1_ready   = 1'b0;
      r0_drdy    = 1'b0;
      r1_drdy    = 1'b0;
      r0_done    = 1'b0;
      r1_done    = 1'b0;
      lcl_den    = 1'b0;
      lcl_idone  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      burst_q    <= '0;
      beat_cnt_q <= '0;
      grant_q    <= 1'b0;
      pref_q     <= 1'b0;
      istart_q   <= 1'b0;
      iaddr_q    <= '0;
      inum_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      burst_q    <= burst_d;
      beat_cnt_q <= beat_cnt_d;
      grant_q    <= grant_d;
      pref_q     <= pref_d;
      istart_q   <= istart_d;
      iaddr_q    <= iaddr_d;
      inum_q     <= inum_d;
    end
  end

endmodule
